mac_out_deskew: RTL

Output collector directly downstream of the 4x4 weight-stationary MAC array. It captures the per-row, time-skewed 16-bit partial sums the array emits (one row valid per cycle, row r one cycle after row r-1) and re-aligns them through per-row FIFOs. It accumulates a programmable number of aligned vectors into 32-bit signed sums and presents each finished 4x32 result on a valid/ready interface to the writeback stage.

---
 rtl/mac_out_deskew.sv | 133 +++++++++++++
 1 files changed

// File: rtl/mac_out_deskew.sv
// Output collector for the 4x4 MAC array: re-aligns skewed per-row partial sums
// through row FIFOs, accumulates ACC_LEN vectors and hands 4x32 results downstream.
module mac_out_deskew #(
  parameter int DEPTH = 4
) (
  input  logic         CLK,
  input  logic         RSTN,
  input  logic [63:0]  IDATA,
  input  logic [3:0]   IVALID,
  input  logic [3:0]   ACC_LEN,
  input  logic         CLR,
  output logic [127:0] ODATA,
  output logic         OVALID,
  input  logic         OREADY,
  output logic [3:0]   ERR,
  output logic         BUSY
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]    r_wptr [4];
  logic [AW:0]    r_rptr [4];
  logic [15:0]    r_mem  [4][DEPTH];
  logic [31:0]    r_acc  [4];
  logic [3:0]     r_cnt;
  logic [3:0]     r_len;
  logic [127:0]   r_odata;
  logic           r_ovalid;
  logic [3:0]     r_err;

  logic [3:0]     w_empty;
  logic [3:0]     w_full;
  logic [3:0]     w_push;
  logic [3:0]     w_drop;
  logic [3:0]     w_len;
  logic           w_last;
  logic           w_pop;
  logic [15:0]    w_head [4];
  logic [31:0]    w_sum  [4];

  // NOTE: every signal written in always_comb gets a default first, so no path
  // can leave it unassigned and infer a latch.
  always_comb begin
    w_empty = '0;
    w_full  = '0;
    for (int r = 0; r < 4; r++) begin
      w_empty[r] = (r_wptr[r] == r_rptr[r]);
      w_full[r]  = (r_wptr[r][AW-1:0] == r_rptr[r][AW-1:0]) &&
                   (r_wptr[r][AW] != r_rptr[r][AW]);
    end
  end

  // LEN is taken live from ACC_LEN on the first beat; 0 wraps to 15 => 16 beats.
  always_comb begin
    w_len  = (r_cnt == 4'd0) ? ACC_LEN : r_len;
    w_last = (r_cnt == (w_len - 4'd1));
    w_pop  = (&(~w_empty)) && !(w_last && r_ovalid && !OREADY);
  end

  always_comb begin
    w_push = '0;
    w_drop = '0;
    for (int r = 0; r < 4; r++) begin
      w_head[r] = r_mem[r][r_rptr[r][AW-1:0]];
      w_sum[r]  = ((r_cnt == 4'd0) ? 32'd0 : r_acc[r]) +
                  {{16{w_head[r][15]}}, w_head[r]};
      w_push[r] = !CLR && IVALID[r] && (!w_full[r] || w_pop);
      w_drop[r] = !CLR && IVALID[r] && w_full[r] && !w_pop;
    end
  end

  // NOTE: FIFO storage carries no reset; pointers alone define valid contents,
  // so a reset or flush only needs to clear the pointers.
  always_ff @(posedge CLK) begin
    for (int r = 0; r < 4; r++) begin
      if (w_push[r]) r_mem[r][r_wptr[r][AW-1:0]] <= IDATA[16*r +: 16];
    end
  end

  // NOTE: all state below updates with non-blocking assignments so every read
  // in this block sees the pre-edge value.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      for (int r = 0; r < 4; r++) begin
        r_wptr[r] <= '0;
        r_rptr[r] <= '0;
        r_acc[r]  <= '0;
      end
      r_cnt    <= '0;
      r_len    <= '0;
      r_odata  <= '0;
      r_ovalid <= 1'b0;
      r_err    <= '0;
    end else if (CLR) begin
      for (int r = 0; r < 4; r++) begin
        r_wptr[r] <= '0;
        r_rptr[r] <= '0;
        r_acc[r]  <= '0;
      end
      r_cnt    <= '0;
      r_ovalid <= 1'b0;
      r_err    <= '0;
    end else begin
      for (int r = 0; r < 4; r++) begin
        if (w_push[r]) r_wptr[r] <= r_wptr[r] + 1'b1;
        if (w_pop)     r_rptr[r] <= r_rptr[r] + 1'b1;
        if (w_drop[r]) r_err[r]  <= 1'b1;
      end

      if (w_pop) begin
        if (r_cnt == 4'd0) r_len <= ACC_LEN;
        if (w_last) begin
          r_odata <= {w_sum[3], w_sum[2], w_sum[1], w_sum[0]};
          r_cnt   <= '0;
          for (int r = 0; r < 4; r++) r_acc[r] <= '0;
        end else begin
          r_cnt <= r_cnt + 4'd1;
          for (int r = 0; r < 4; r++) r_acc[r] <= w_sum[r];
        end
      end

      // A last-beat pop reloads the output in the same edge as a handshake.
      if (w_pop && w_last) r_ovalid <= 1'b1;
      else if (OREADY)     r_ovalid <= 1'b0;
    end
  end

  assign ODATA  = r_odata;
  assign OVALID = r_ovalid;
  assign ERR    = r_err;
  assign BUSY   = (|(~w_empty)) || (r_cnt != 4'd0);

endmodule
